dac_mcp4725_update_arbiter: RTL

//  Shares one MCP4725 DAC among N_REQ requesters. Each requester asks for a 12-bit code.
//  The block picks one requester by round-robin and builds the 3-byte fast-mode write

---
 rtl/dac_mcp4725_update_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dac_mcp4725_update_arbiter.sv
// Round-robin arbiter that shares one MCP4725 DAC among N_REQ requesters and sequences
// 3-byte fast-mode write frames through an I2C write engine with power-up delay, NACK retry and bus gap.
`timescale 1ns/1ps
module dac_mcp4725_update_arbiter #(
  parameter int          N_REQ       = 4,
  parameter logic [6:0]  DAC_ADDR    = 7'h61,
  parameter logic [1:0]  PD_MODE     = 2'b00,
  parameter int          POWERUP_CYC = 250,
  parameter int          GAP_CYC     = 250,
  parameter int          MAX_RETRY   = 2
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [12*N_REQ-1:0] i_code,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_done,
  output logic               o_err,
  output logic [2:0]         o_owner,
  output logic               o_busy,
  output logic               o_eng_start,
  output logic [23:0]        o_eng_frame,
  input  logic               i_eng_busy,
  input  logic               i_eng_done,
  input  logic               i_eng_nack
);

  typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t      state;
  state_t      gap_next;
  logic [15:0] cnt;
  logic [3:0]  retries;
  logic [2:0]  ptr;

  logic [7:0]  req_ext;
  logic [3:0]  cand;
  logic [2:0]  pick_idx;
  logic        pick_vld;
  logic [11:0] pick_code;
  logic [2:0]  ptr_nxt;

  // First set request at or after ptr, scanning with wrap-around.
  always_comb begin
    req_ext  = 8'(i_req);
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!pick_vld && req_ext[cand[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[2:0];
      end
    end
    pick_code = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == 3'(k)) pick_code = i_code[12*k +: 12];
    end
    ptr_nxt = (pick_idx == 3'(N_REQ-1)) ? 3'd0 : pick_idx + 3'd1;
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state       <= S_PWRUP;
      gap_next    <= S_IDLE;
      cnt         <= '0;
      retries     <= '0;
      ptr         <= '0;
      o_grant     <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_owner     <= '0;
      o_busy      <= 1'b0;
      o_eng_start <= 1'b0;
      o_eng_frame <= '0;
    end else begin
      o_grant     <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_eng_start <= 1'b0;
      o_busy      <= 1'b1;
      case (state)
        S_PWRUP: begin
          if (cnt == 16'(POWERUP_CYC-1)) begin
            cnt    <= '0;
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_IDLE: begin
          if (pick_vld) begin
            for (int k = 0; k < N_REQ; k++) o_grant[k] <= (pick_idx == 3'(k));
            o_eng_frame <= {DAC_ADDR, 1'b0, 2'b00, PD_MODE, pick_code};
            o_owner     <= pick_idx;
            ptr         <= ptr_nxt;
            retries     <= '0;
            state       <= S_LAUNCH;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (!i_eng_busy) begin
            o_eng_start <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_eng_done) begin
            cnt   <= '0;
            state <= S_GAP;
            if (!i_eng_nack) begin
              o_done   <= 1'b1;
              gap_next <= S_IDLE;
            end else if (retries < 4'(MAX_RETRY)) begin
              // Resend the same latched frame; arbitration is not revisited.
              retries  <= retries + 4'd1;
              gap_next <= S_LAUNCH;
            end else begin
              o_err    <= 1'b1;
              gap_next <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (cnt == 16'(GAP_CYC-1)) begin
            cnt   <= '0;
            state <= gap_next;
            if (gap_next == S_IDLE) o_busy <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule
